snn_step_scheduler: RTL and testbench

Timestep scheduler and shared-arithmetic controller for the 3-input / 3-neuron spiking network. It generates the network timestep tick and latches `spikes_in` on each tick. It then sequences one shared accumulate/leak/fire datapath across all neurons in turn and publishes `spikes_out` once per timestep. It also holds the configuration register file (weights, threshold, leak) written by the SPI slave, and sits between the SPI slave and the pad-level `spikes_in`/`spikes_out` wiring inside `top`.

---
 rtl/snn_pkg.sv | 42 ++++
 rtl/snn_cfg_regs.sv | 60 ++++++
 rtl/snn_step_scheduler.sv | 179 +++++++++++++++++
 tb/tb_snn_step_scheduler.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared constants, state encoding and saturation helper for the SNN
// timestep scheduler and its configuration register file.
package snn_pkg;

    localparam int N_IN_DEF  = 3;
    localparam int N_NEU_DEF = 3;

    localparam logic [3:0] ADDR_THRESH = 4'd9;
    localparam logic [3:0] ADDR_LEAK   = 4'd10;

    localparam logic [7:0] THRESH_RST = 8'd16;
    localparam logic [7:0] LEAK_RST   = 8'd1;

    localparam int V_W   = 8;
    localparam int ACC_W = 10;
    localparam int VN_W  = 11;

    localparam logic signed [VN_W-1:0] VN_MAX = 11'sd127;
    localparam logic signed [VN_W-1:0] VN_MIN = -11'sd128;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_ACCUM,
        ST_FIRE,
        ST_DONE
    } sched_state_t;

    // Clamp a wide membrane candidate into the signed 8-bit membrane range.
    function automatic logic signed [V_W-1:0] sat_v(input logic signed [VN_W-1:0] x);
        logic signed [V_W-1:0] r;
        if (x > VN_MAX) begin
            r = 8'sh7f;
        end else if (x < VN_MIN) begin
            r = 8'sh80;
        end else begin
            r = x[V_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/snn_cfg_regs.sv
// Configuration register file: weights, threshold and leak written by the
// SPI slave, with a combinational weight read port addressed by (j, i).
module snn_cfg_regs
    import snn_pkg::*;
#(
    parameter int N_IN  = N_IN_DEF,
    parameter int N_NEU = N_NEU_DEF,
    parameter int J_W   = 2,
    parameter int I_W   = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           we,
    input  logic [3:0]     addr,
    input  logic [7:0]     wdata,
    input  logic [J_W-1:0] rd_j,
    input  logic [I_W-1:0] rd_i,
    output logic [7:0]     weight,
    output logic [7:0]     thresh,
    output logic [7:0]     leak
);

    localparam int N_W = N_IN * N_NEU;

    logic [7:0] w [N_W];
    logic [7:0] thresh_q;
    logic [7:0] leak_q;
    logic [4:0] rd_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_W; k++) begin
                w[k] <= '0;
            end
            thresh_q <= THRESH_RST;
            leak_q   <= LEAK_RST;
        end else if (we) begin
            // Addresses past the leak register fall through every branch.
            if ({1'b0, addr} < 5'(N_W)) begin
                w[addr] <= wdata;
            end else if (addr == ADDR_THRESH) begin
                thresh_q <= wdata;
            end else if (addr == ADDR_LEAK) begin
                leak_q <= wdata;
            end
        end
    end

    always_comb begin
        rd_idx = 5'(rd_j) * 5'(N_IN) + 5'(rd_i);
        weight = '0;
        if (rd_idx < 5'(N_W)) begin
            weight = w[rd_idx[3:0]];
        end
    end

    assign thresh = thresh_q;
    assign leak   = leak_q;

endmodule

// File: rtl/snn_step_scheduler.sv
// Timestep tick generator and shared accumulate/leak/fire sequencer for the
// small spiking network; owns the membranes and publishes spikes_out per step.
module snn_step_scheduler
    import snn_pkg::*;
#(
    parameter int N_IN        = N_IN_DEF,
    parameter int N_NEU       = N_NEU_DEF,
    parameter int TICK_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N_IN-1:0]  spikes_in,
    input  logic             cfg_we,
    input  logic [3:0]       cfg_addr,
    input  logic [7:0]       cfg_wdata,
    output logic [N_NEU-1:0] spikes_out,
    output logic             busy,
    output logic             step_done
);

    localparam int J_W   = (N_NEU > 1) ? $clog2(N_NEU) : 1;
    localparam int I_W   = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int CNT_W = $clog2(TICK_CYCLES);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYCLES - 1);
    localparam logic [J_W-1:0]   J_LAST   = J_W'(N_NEU - 1);
    localparam logic [I_W-1:0]   I_LAST   = I_W'(N_IN - 1);

    if (TICK_CYCLES < N_NEU * (N_IN + 1) + 4) begin : g_bad_tick
        $error("TICK_CYCLES too short to fit one update sequence");
    end
    if (N_IN * N_NEU + 2 > 16) begin : g_bad_map
        $error("N_IN*N_NEU+2 exceeds the 16-entry register map");
    end

    logic [CNT_W-1:0]       cnt;
    logic                   tick;
    logic [N_IN-1:0]        sync1;
    logic [N_IN-1:0]        sync2;
    logic [N_IN-1:0]        spk_lat;
    sched_state_t           state;
    sched_state_t           state_n;
    logic [J_W-1:0]         j;
    logic [I_W-1:0]         i;
    logic signed [ACC_W-1:0] acc;
    logic signed [V_W-1:0]  v [N_NEU];
    logic [N_NEU-1:0]       spk_nxt;
    logic [N_NEU-1:0]       spk_fin;
    logic [7:0]             weight;
    logic [7:0]             thresh;
    logic [7:0]             leak;
    logic signed [VN_W-1:0] vn;
    logic signed [V_W-1:0]  v_sat;
    logic                   fire;

    snn_cfg_regs #(
        .N_IN  (N_IN),
        .N_NEU (N_NEU),
        .J_W   (J_W),
        .I_W   (I_W)
    ) u_cfg (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (cfg_we),
        .addr   (cfg_addr),
        .wdata  (cfg_wdata),
        .rd_j   (j),
        .rd_i   (i),
        .weight (weight),
        .thresh (thresh),
        .leak   (leak)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (en) begin
                if (cnt == CNT_LAST) begin
                    cnt  <= '0;
                    tick <= 1'b1;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= spikes_in;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:  if (tick) state_n = ST_LATCH;
            ST_LATCH: state_n = ST_ACCUM;
            ST_ACCUM: if (i == I_LAST) state_n = ST_FIRE;
            ST_FIRE:  state_n = (j == J_LAST) ? ST_DONE : ST_ACCUM;
            ST_DONE:  state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    // 11 bits covers -128-384-255 .. 127+381, so the sum never wraps.
    always_comb begin
        vn      = VN_W'(v[j]) + VN_W'(acc) - {3'b000, leak};
        v_sat   = sat_v(vn);
        fire    = v_sat >= $signed(thresh);
        spk_fin = spk_nxt;
        spk_fin[j] = fire;
    end

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spk_lat    <= '0;
            acc        <= '0;
            j          <= '0;
            i          <= '0;
            spk_nxt    <= '0;
            spikes_out <= '0;
            step_done  <= 1'b0;
            for (int k = 0; k < N_NEU; k++) begin
                v[k] <= '0;
            end
        end else begin
            step_done <= 1'b0;
            case (state)
                ST_LATCH: begin
                    spk_lat <= sync2;
                    acc     <= '0;
                    j       <= '0;
                    i       <= '0;
                end
                ST_ACCUM: begin
                    if (spk_lat[i]) begin
                        acc <= acc + ACC_W'($signed(weight));
                    end
                    i <= i + I_W'(1);
                end
                ST_FIRE: begin
                    spk_nxt <= spk_fin;
                    v[j]    <= fire ? '0 : v_sat;
                    acc     <= '0;
                    i       <= '0;
                    if (j != J_LAST) begin
                        j <= j + J_W'(1);
                    end else begin
                        // Published on the edge into DONE so step_done and the
                        // new spikes appear together in the DONE cycle.
                        spikes_out <= spk_fin;
                        step_done  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_snn_step_scheduler.sv
// Randomised scoreboard bench for snn_step_scheduler with an integer-level
// network model and a per-cycle tick/busy/step_done timing checker.
module tb_snn_step_scheduler;

    localparam int T = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b0;
    logic [2:0] spikes_in = '0;
    logic       cfg_we = 1'b0;
    logic [3:0] cfg_addr = '0;
    logic [7:0] cfg_wdata = '0;
    logic [2:0] spikes_out;
    logic       busy;
    logic       step_done;

    snn_step_scheduler #(
        .N_IN        (3),
        .N_NEU       (3),
        .TICK_CYCLES (T)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .spikes_in  (spikes_in),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .spikes_out (spikes_out),
        .busy       (busy),
        .step_done  (step_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [2:0] exp_q[$];

    int cyc = 0;
    bit timing_on = 1'b0;
    int sidx = 0;
    logic [2:0] prev_out = '0;
    logic [2:0] mon_exp;

    int w_m [9];
    int th_m;
    int lk_m;
    int v_m [3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 9; k++) w_m[k] = 0;
        th_m = 16;
        lk_m = 1;
        for (int k = 0; k < 3; k++) v_m[k] = 0;
    endtask

    task automatic model_step(input logic [2:0] spk, output logic [2:0] out);
        out = '0;
        for (int n = 0; n < 3; n++) begin
            int sum;
            int vn;
            sum = 0;
            for (int k = 0; k < 3; k++) begin
                if (spk[k]) sum += w_m[n*3 + k];
            end
            vn = v_m[n] + sum - lk_m;
            if (vn > 127) vn = 127;
            if (vn < -128) vn = -128;
            if (vn >= th_m) begin
                out[n] = 1'b1;
                v_m[n] = 0;
            end else begin
                v_m[n] = vn;
            end
        end
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [7:0] d);
        cfg_we = 1'b1;
        cfg_addr = a;
        cfg_wdata = d;
        @(negedge clk);
        cfg_we = 1'b0;
        if (int'(a) < 9) w_m[a] = int'($signed(d));
        else if (int'(a) == 9) th_m = int'($signed(d));
        else if (int'(a) == 10) lk_m = int'(d);
    endtask

    task automatic wait_cyc(input int target);
        int budget;
        budget = 4*T + 50;
        while (cyc < target && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (cyc < target) begin
            total++;
            bad++;
            $display("FAIL wait_cyc: reached %0d want %0d", cyc, target);
        end
    endtask

    task automatic launch(input logic [2:0] spk);
        logic [2:0] e;
        spikes_in = spk;
        model_step(spk, e);
        exp_q.push_back(e);
        repeat (3) @(negedge clk);
        en = 1'b1;
        sidx++;
    endtask

    task automatic finish_step();
        wait_cyc(sidx*T + 15);
        en = 1'b0;
    endtask

    task automatic rand_write();
        logic [3:0] a;
        logic [7:0] d;
        a = 4'($urandom_range(0, 15));
        if (int'(a) == 9) d = 8'(int'($urandom_range(0, 60)) - 10);
        else if (int'(a) == 10) d = 8'($urandom_range(0, 4));
        else d = 8'($urandom_range(0, 255));
        cfg_write(a, d);
    endtask

    // Counter mirror: one count per clock in which en is sampled high.
    always @(posedge clk) begin
        if (!timing_on) cyc <= 0;
        else if (en) cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_out = '0;
        end else if (timing_on) begin
            check("step_done_timing", 32'(step_done), 32'(cyc >= T && cyc % T == 14));
            check("busy_timing", 32'(busy), 32'(cyc > T && cyc % T >= 1 && cyc % T <= 14));
            if (!step_done) check("spikes_out_hold", 32'(spikes_out), 32'(prev_out));
            prev_out = spikes_out;
        end
    end

    always @(negedge clk) begin
        if (rst_n && step_done) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_step_done: got pulse want none at %0t", $time);
            end else begin
                mon_exp = exp_q.pop_front();
                check("spikes_out", 32'(spikes_out), 32'(mon_exp));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_spikes_out", 32'(spikes_out), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_step_done", 32'(step_done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        timing_on = 1'b1;

        // single-step fire
        cfg_write(4'd0, 8'd20);
        launch(3'b001);
        finish_step();

        // leak integration over four steps
        cfg_write(4'd0, 8'd5);
        for (int s = 0; s < 4; s++) begin
            launch(3'b001);
            finish_step();
        end

        // saturation in both directions
        for (int k = 3; k < 6; k++) cfg_write(4'(k), 8'd127);
        for (int k = 6; k < 9; k++) cfg_write(4'(k), 8'h80);
        cfg_write(4'd9, 8'd127);
        launch(3'b111);
        finish_step();
        launch(3'b111);
        finish_step();
        cfg_write(4'd9, 8'd16);

        // ignored address, then a weight write during neuron 2 accumulate
        cfg_write(4'd12, 8'h55);
        launch(3'b111);
        finish_step();
        cfg_write(4'd0, 8'd2);
        launch(3'b001);
        wait_cyc(sidx*T + 10);
        cfg_write(4'd0, 8'd100);
        finish_step();
        launch(3'b001);
        finish_step();

        for (int s = 0; s < 25; s++) begin
            int nw;
            nw = int'($urandom_range(0, 3));
            for (int k = 0; k < nw; k++) rand_write();
            repeat ($urandom_range(0, 3)) @(negedge clk);
            launch(3'($urandom_range(0, 7)));
            finish_step();
        end

        // drive neuron 0 high so the reset below clears a set output
        cfg_write(4'd0, 8'd100);
        cfg_write(4'd9, 8'd16);
        cfg_write(4'd10, 8'd1);
        launch(3'b001);
        finish_step();
        launch(3'b001);
        finish_step();

        launch(3'b111);
        wait_cyc(sidx*T + 7);
        rst_n = 1'b0;
        timing_on = 1'b0;
        exp_q.delete();
        model_reset();
        #1;
        check("midreset_spikes_out", 32'(spikes_out), 32'd0);
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_step_done", 32'(step_done), 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("inreset_step_done", 32'(step_done), 32'd0);
            check("inreset_busy", 32'(busy), 32'd0);
        end
        rst_n = 1'b1;
        timing_on = 1'b1;
        sidx = 0;
        begin
            logic [2:0] e;
            cfg_write(4'd7, 8'd50);
            spikes_in = 3'b010;
            model_step(3'b010, e);
            exp_q.push_back(e);
            sidx = 1;
        end
        wait_cyc(T + 15);

        repeat (3) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
